// File: rtl/execute_cycle.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU,
// branch resolution and the EX/MEM pipeline register.
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);

    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        zero;

    logic        reg_write_d, reg_write_q;
    logic        mem_write_d, mem_write_q;
    logic        result_src_d, result_src_q;
    logic [4:0]  rd_d, rd_q;
    logic [31:0] alu_result_d, alu_result_q;
    logic [31:0] write_data_d, write_data_q;
    logic [31:0] pc_plus4_d, pc_plus4_q;

    // Forwarding muxes; the 10 path feeds back this stage's own registered result
    always_comb begin
        unique case (ForwardA_E)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
        unique case (ForwardB_E)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = alu_result_q;
            default: fwd_b = RD2_E;
        endcase
        src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
    end

    // ALU; SLT compares as signed values rather than testing the difference's sign
    always_comb begin
        unique case (ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            3'b101:  alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
            3'b110:  alu_result = {31'b0, src_a < src_b};
            default: alu_result = src_a << src_b[4:0];
        endcase
    end

    // Branch decision (beq only) and target address
    always_comb begin
        zero      = (alu_result == '0);
        PCSrcE    = BranchE & zero;
        PCTargetE = PCE + Imm_Ext_E;
    end

    // Next-state values for the EX/MEM register; no stall, every edge captures
    always_comb begin
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        rd_d         = RD_E;
        alu_result_d = alu_result;
        write_data_d = fwd_b;
        pc_plus4_d   = PCPlus4E;
    end

    // EX/MEM pipeline register with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign RD_M       = rd_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: driver issues one instruction per
// cycle and queues the expected EX/MEM contents; a monitor pops and compares.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteE = 1'b0, ALUSrcE = 1'b0, MemWriteE = 1'b0;
    logic        ResultSrcE = 1'b0, BranchE = 1'b0;
    logic [2:0]  ALUControlE = '0;
    logic [31:0] RD1_E = '0, RD2_E = '0, Imm_Ext_E = '0;
    logic [4:0]  RD_E = '0;
    logic [31:0] PCE = '0, PCPlus4E = '0;
    logic [1:0]  ForwardA_E = '0, ForwardB_E = '0;
    logic [31:0] ResultW = '0;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rw, src, mw, rs, br;
        bit [2:0]  op;
        bit [31:0] rd1, rd2, imm;
        bit [4:0]  rd;
        bit [31:0] pc, pc4;
        bit [1:0]  fa, fb;
        bit [31:0] resw;
    } stim_t;

    typedef struct {
        bit        rw, mw, rs;
        bit [4:0]  rd;
        bit [31:0] alu, wd, pc4;
    } exp_t;

    exp_t      exp_q[$];
    bit [31:0] model_alu_m = '0;   // what the model believes ALUResultM holds
    int        tests = 0;
    int        fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference ALU from the instruction definitions, using wide integer arithmetic
    function automatic bit [31:0] ref_alu(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = a[31] ? ua - 64'h1_0000_0000 : ua;
        longint sb = b[31] ? ub - 64'h1_0000_0000 : ub;
        longint r;
        case (op)
            3'd0: r = ua + ub;
            3'd1: r = ua - ub + 64'h1_0000_0000;
            3'd2: r = longint'(a & b);
            3'd3: r = longint'(a | b);
            3'd4: r = longint'(a ^ b);
            3'd5: r = (sa < sb) ? 1 : 0;
            3'd6: r = (ua < ub) ? 1 : 0;
            default: r = ua * (longint'(1) << (ub % 32));
        endcase
        return r[31:0];
    endfunction

    function automatic bit [31:0] pick(input bit [1:0] sel, input bit [31:0] rf, input bit [31:0] w, input bit [31:0] m);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return rf;
    endfunction

    function automatic stim_t blank();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    // Drive one instruction at the falling edge, queue its EX/MEM image, check combinational outputs
    task automatic issue(input stim_t s);
        bit [31:0] a, bm, b, r;
        exp_t e;
        @(negedge clk);
        RegWriteE = s.rw; ALUSrcE = s.src; MemWriteE = s.mw; ResultSrcE = s.rs;
        BranchE = s.br; ALUControlE = s.op; RD1_E = s.rd1; RD2_E = s.rd2;
        Imm_Ext_E = s.imm; RD_E = s.rd; PCE = s.pc; PCPlus4E = s.pc4;
        ForwardA_E = s.fa; ForwardB_E = s.fb; ResultW = s.resw;
        a  = pick(s.fa, s.rd1, s.resw, model_alu_m);
        bm = pick(s.fb, s.rd2, s.resw, model_alu_m);
        b  = s.src ? s.imm : bm;
        r  = ref_alu(s.op, a, b);
        e.rw = s.rw; e.mw = s.mw; e.rs = s.rs; e.rd = s.rd;
        e.alu = r; e.wd = bm; e.pc4 = s.pc4;
        exp_q.push_back(e);
        model_alu_m = r;
        #2;
        check("pcsrc", 32'(PCSrcE), 32'(s.br && (r == 0)));
        check("pctarget", PCTargetE, 32'((longint'(s.pc) + longint'(s.imm)) % 64'h1_0000_0000));
    endtask

    // Monitor: after each edge out of reset, compare EX/MEM against the oldest queued entry
    always begin
        @(posedge clk);
        #1;
        if (rst && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("regwrite_m", 32'(RegWriteM), 32'(e.rw));
            check("memwrite_m", 32'(MemWriteM), 32'(e.mw));
            check("resultsrc_m", 32'(ResultSrcM), 32'(e.rs));
            check("rd_m", 32'(RD_M), 32'(e.rd));
            check("aluresult_m", ALUResultM, e.alu);
            check("writedata_m", WriteDataM, e.wd);
            check("pcplus4_m", PCPlus4M, e.pc4);
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_rw"}, 32'(RegWriteM), 0);
        check({name, "_mw"}, 32'(MemWriteM), 0);
        check({name, "_rs"}, 32'(ResultSrcM), 0);
        check({name, "_rd"}, 32'(RD_M), 0);
        check({name, "_alu"}, ALUResultM, 0);
        check({name, "_wd"}, WriteDataM, 0);
        check({name, "_pc4"}, PCPlus4M, 0);
    endtask

    task automatic alu_after_edge(input string name, input bit [31:0] exp);
        @(posedge clk);
        #2;
        check(name, ALUResultM, exp);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        stim_t s;
        bit [2:0]  ops[6] = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd4, 3'd7};
        bit [31:0] sweep[6] = '{32'h0, 32'hFFFFFFFE, 32'h1, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFE};

        #3;
        check_all_zero("reset_init");
        @(negedge clk);
        rst = 1'b1;

        // ALU sweep with SrcA=all-ones, SrcB=1
        for (int i = 0; i < 6; i++) begin
            s = blank(); s.op = ops[i]; s.rd1 = 32'hFFFFFFFF; s.rd2 = 32'h1;
            issue(s);
            alu_after_edge("alu_sweep", sweep[i]);
        end

        // Immediate path: store data still comes from RD2
        s = blank(); s.src = 1; s.rd1 = 100; s.imm = 32'hFFFFFFFC; s.rd2 = 32'hDEADBEEF;
        issue(s);
        @(posedge clk); #2;
        check("imm_alu", ALUResultM, 96);
        check("imm_wd", WriteDataM, 32'hDEADBEEF);

        // Forwarding chain
        s = blank(); s.rd1 = 2; s.rd2 = 3;
        issue(s);
        alu_after_edge("fwd_c1", 5);
        s = blank(); s.fa = 2'b10; s.rd2 = 4;
        issue(s);
        alu_after_edge("fwd_c2", 9);
        s = blank(); s.fb = 2'b01; s.resw = 32'h10; s.rd1 = 1; s.op = 3'd1;
        issue(s);
        alu_after_edge("fwd_c3", 32'hFFFFFFF1);

        // Both operands forwarded from ALUResultM
        s = blank(); s.fa = 2'b10; s.fb = 2'b10; s.op = 3'd0;
        issue(s);
        alu_after_edge("fwd_both", 32'hFFFFFFE2);

        // Branch taken / not taken
        s = blank(); s.br = 1; s.op = 3'd1; s.rd1 = 32'h55; s.rd2 = 32'h55;
        s.pc = 32'h100; s.imm = 32'hFFFFFFF0;
        issue(s);
        check("br_taken", 32'(PCSrcE), 1);
        check("br_target", PCTargetE, 32'hF0);
        s.rd2 = 32'h56;
        issue(s);
        check("br_not_taken", 32'(PCSrcE), 0);

        // SLL by zero and by an amount with upper bits set
        s = blank(); s.op = 3'd7; s.rd1 = 32'h1234ABCD; s.rd2 = 32'h0;
        issue(s);
        alu_after_edge("sll_zero", 32'h1234ABCD);
        s.rd2 = 32'hFFFFFFE4;
        issue(s);
        alu_after_edge("sll_masked", 32'h234ABCD0);

        // Control propagation then bubble
        s = blank(); s.rw = 1; s.mw = 1; s.rs = 1; s.pc4 = 32'h204; s.rd = 5'd9;
        issue(s);
        @(posedge clk); #2;
        check("ctl_rw", 32'(RegWriteM), 1);
        check("ctl_mw", 32'(MemWriteM), 1);
        check("ctl_rs", 32'(ResultSrcM), 1);
        check("ctl_pc4", PCPlus4M, 32'h204);
        issue(blank());
        @(posedge clk); #2;
        check("bubble_rw", 32'(RegWriteM), 0);
        check("bubble_mw", 32'(MemWriteM), 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            s.rw = 1'($urandom); s.src = 1'($urandom); s.mw = 1'($urandom);
            s.rs = 1'($urandom); s.br = 1'($urandom); s.op = 3'($urandom);
            s.rd1 = $urandom; s.rd2 = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
            s.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            s.rd = 5'($urandom); s.pc = $urandom; s.pc4 = $urandom;
            s.fa = 2'($urandom); s.fb = 2'($urandom); s.resw = $urandom;
            issue(s);
        end

        // Reset in the middle of operation
        s = blank(); s.rd1 = 5; s.rd2 = 7; s.rw = 1; s.rd = 5'd4; s.pc4 = 32'h44;
        issue(s);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check_all_zero("reset_mid");
        exp_q.delete();
        model_alu_m = '0;
        @(posedge clk); #1;
        check_all_zero("reset_hold");
        #2;
        rst = 1'b1;
        s = blank(); s.rd = 5'd3;
        issue(s);
        @(posedge clk); #2;
        check("reset_release_rd", 32'(RD_M), 3);

        @(posedge clk); #2;
        check("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
